// File: rtl/imgproc_msg_pkg.sv
// Shared constants and types for the image-processor message reader.
//  - CSR word addresses and the FLUSH control bit in STATUS
//  - Default message ID ("RBB") and packet sync byte
//  - Reader FSM state type and output packet length
//  - xor_bytes(): XOR-reduction of the 8 payload bytes (packet checksum)
package imgproc_msg_pkg;

  localparam logic [2:0]  ADDR_STATUS   = 3'd0;
  localparam logic [2:0]  ADDR_READ_MSG = 3'd1;
  localparam int unsigned FLUSH_BIT     = 4;

  localparam logic [31:0] MSG_ID    = 32'h0052_4242;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned PKT_BYTES = 10;

  typedef enum logic [3:0] {
    StIdle,
    StRdStat,
    StWaitStat,
    StRdId,
    StWaitId,
    StRdW1,
    StWaitW1,
    StRdW2,
    StWaitW2,
    StEmit,
    StFlush
  } state_e;

  function automatic logic [7:0] xor_bytes(input logic [63:0] data);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc ^= data[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/msg_byte_serializer.sv
// Turns two captured message words into a framed byte stream:
//   SYNC_BYTE, w1[31:24] .. w1[7:0], w2[31:24] .. w2[7:0], XOR of the 8 payload bytes.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   load            1-cycle pulse: capture w1/w2 and start a packet (ignored mid-packet by design
//                   of the caller, which only loads when idle)
//   w1, w2          message payload words
//   tx_data/valid   byte stream out; tx_data held while tx_valid & ~tx_ready
//   tx_ready        downstream accept
//   done            1-cycle pulse coincident with acceptance of the last byte
module msg_byte_serializer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] w1,
  input  logic [31:0] w2,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);
  import imgproc_msg_pkg::*;

  localparam logic [3:0] LastIdx = 4'(PKT_BYTES - 1);

  logic        active_q, active_d;
  logic [3:0]  idx_q, idx_d;
  logic [63:0] shift_q, shift_d;
  logic [7:0]  csum_q, csum_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      shift_q  <= '0;
      csum_q   <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      csum_q   <= csum_d;
    end
  end

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    csum_d   = csum_q;
    done     = 1'b0;
    if (load) begin
      active_d = 1'b1;
      idx_d    = '0;
      shift_d  = {w1, w2};
      csum_d   = xor_bytes({w1, w2});
    end else if (active_q && tx_ready) begin
      // Payload bytes leave from the top of the shift register.
      if (idx_q != 4'd0 && idx_q != LastIdx) begin
        shift_d = {shift_q[55:0], 8'h00};
      end
      if (idx_q == LastIdx) begin
        active_d = 1'b0;
        idx_d    = '0;
        done     = 1'b1;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    tx_data = '0;
    if (active_q) begin
      if (idx_q == 4'd0) begin
        tx_data = SYNC_BYTE;
      end else if (idx_q == LastIdx) begin
        tx_data = csum_q;
      end else begin
        tx_data = shift_q[63:56];
      end
    end
  end

  assign tx_valid = active_q;

endmodule

// File: rtl/imgproc_msg_reader.sv
// Avalon-MM initiator draining the image-processor message FIFO and forwarding each 3-word
// message ("RBB" ID, crosshair, match count) as a 10-byte packet to a UART TX byte port.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   enable                allow polling; deassertion lets the current packet finish
//   flush_req             1-cycle pulse requesting a FIFO flush (write FLUSH bit to STATUS)
//   m_*                   Avalon-MM initiator (fixed read latency 1, no waitrequest)
//   tx_data/valid/ready   UART TX byte handshake
//   msg_count             packets fully sent (wrapping)
//   sync_err_count        non-ID words discarded (saturating)
//   busy                  FSM not idle
module imgproc_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter logic [31:0] MSG_ID        = 32'h0052_4242,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        flush_req,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] msg_count,
  output logic [15:0] sync_err_count,
  output logic        busy
);
  import imgproc_msg_pkg::*;

  localparam int unsigned      TimerW      = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TimerW-1:0] TimerReload = TimerW'(POLL_INTERVAL - 1);
  localparam logic [31:0]      FlushData   = 32'(1) << FLUSH_BIT;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       w1_q, w1_d;
  logic [15:0]       msg_count_q, msg_count_d;
  logic [15:0]       sync_err_q, sync_err_d;
  logic              ser_load;
  logic              ser_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      w1_q         <= '0;
      msg_count_q  <= '0;
      sync_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      w1_q         <= w1_d;
      msg_count_q  <= msg_count_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Strobes only come from Rd*/Flush states, each of which is entered from a non-strobing
  // state, so consecutive strobes are always separated by at least one idle bus cycle.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    flush_pend_d = flush_pend_q | flush_req;
    w1_d         = w1_q;
    msg_count_d  = msg_count_q;
    sync_err_d   = sync_err_q;
    ser_load     = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = ADDR_STATUS;
    m_writedata  = '0;

    unique case (state_q)
      StIdle: begin
        if (flush_pend_q) begin
          state_d = StFlush;
        end else if (timer_q == '0) begin
          if (enable) state_d = StRdStat;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StRdStat: begin
        m_read  = 1'b1;
        state_d = StWaitStat;
      end
      StWaitStat: begin
        if (m_readdata[15:8] >= 8'd3) begin
          state_d = StRdId;
        end else begin
          timer_d = TimerReload;
          state_d = StIdle;
        end
      end
      StRdId: begin
        m_read    = 1'b1;
        m_address = ADDR_READ_MSG;
        state_d   = StWaitId;
      end
      StWaitId: begin
        if (m_readdata == MSG_ID) begin
          state_d = StRdW1;
        end else begin
          // Re-poll immediately so the hunt advances one word per poll.
          if (sync_err_q != 16'hFFFF) sync_err_d = sync_err_q + 16'd1;
          timer_d = '0;
          state_d = StIdle;
        end
      end
      StRdW1: begin
        m_read    = 1'b1;
        m_address = ADDR_READ_MSG;
        state_d   = StWaitW1;
      end
      StWaitW1: begin
        w1_d    = m_readdata;
        state_d = StRdW2;
      end
      StRdW2: begin
        m_read    = 1'b1;
        m_address = ADDR_READ_MSG;
        state_d   = StWaitW2;
      end
      StWaitW2: begin
        ser_load = 1'b1;
        state_d  = StEmit;
      end
      StEmit: begin
        if (ser_done) begin
          msg_count_d = msg_count_q + 16'd1;
          timer_d     = '0;
          state_d     = StIdle;
        end
      end
      StFlush: begin
        m_write      = 1'b1;
        m_writedata  = FlushData;
        flush_pend_d = 1'b0;
        timer_d      = TimerReload;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    m_chipselect = m_read | m_write;
  end

  msg_byte_serializer #(
    .SYNC_BYTE(SYNC_BYTE)
  ) u_serializer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (ser_load),
    .w1      (w1_q),
    .w2      (m_readdata),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .done    (ser_done)
  );

  assign msg_count      = msg_count_q;
  assign sync_err_count = sync_err_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Scoreboard bench for imgproc_msg_reader: an Avalon slave model backed by a word queue,
// expected packet bytes queued at stimulus time and popped by an independent monitor.
module tb_imgproc_msg_reader;

  localparam int unsigned P      = 40;
  localparam logic [31:0] ID     = 32'h0052_4242;
  localparam logic [31:0] W1A    = 32'h0140_00F0;
  localparam logic [31:0] W2A    = 32'h0000_0123;
  localparam logic [31:0] W1B    = 32'h0280_01E0;
  localparam logic [31:0] W2B    = 32'h0000_0042;
  localparam logic [31:0] W1C    = 32'h0010_0020;
  localparam logic [31:0] W2C    = 32'h0000_0007;
  // Hand-computed packets: sync, 8 payload bytes, XOR of payload bytes.
  localparam logic [79:0] PKT_A  = 80'hA5_01_40_00_F0_00_00_01_23_93;
  localparam logic [79:0] PKT_B  = 80'hA5_02_80_01_E0_00_00_00_42_21;
  localparam logic [79:0] PKT_C  = 80'hA5_00_10_00_20_00_00_00_07_37;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        flush_req;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] msg_count, sync_err_count;
  logic        busy;

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [31:0] fifo[$];
  logic [7:0]  exp_q[$];
  int          stat_times[$];
  int          n_stat = 0, n_msgrd = 0, n_wr = 0, n_acc = 0;
  int          last_wr_cyc = 0, last_acc_cyc = 0;
  logic [2:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  imgproc_msg_reader #(
    .POLL_INTERVAL(P),
    .MSG_ID       (ID),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .flush_req     (flush_req),
    .m_chipselect  (m_chipselect),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .msg_count     (msg_count),
    .sync_err_count(sync_err_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter and tx_ready pattern, updated just after each rising edge.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Avalon slave model: STATUS[15:8] = words held, READ_MSG pops, write of bit 4 flushes.
  initial begin
    m_readdata <= '0;
    forever begin
      @(posedge clk);
      if (m_read) begin
        if (m_address == 3'd0) begin
          m_readdata <= {16'h0, 8'(fifo.size()), 8'h0};
        end else if (m_address == 3'd1) begin
          if (fifo.size() > 0) m_readdata <= fifo.pop_front();
          else m_readdata <= 32'h0;
        end
      end
      if (m_write && m_address == 3'd0 && m_writedata[4]) fifo.delete();
    end
  end

  // Monitor: bus protocol, stall hold and scoreboard pops, sampled at the falling edge.
  initial begin : monitor
    logic       strobe;
    logic       prev_strobe;
    logic       prev_stall;
    logic [7:0] held;
    logic [7:0] exp_b;
    prev_strobe = 1'b0;
    prev_stall  = 1'b0;
    held        = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        strobe = m_read | m_write;
        if (strobe) begin
          n_vec++;
          if (prev_strobe || !m_chipselect || (m_read && m_write)) begin
            n_fail++;
            $display("FAIL bus_strobe cyc=%0d: cs=%b rd=%b wr=%b prev_strobe=%b, required cs=1 one strobe no adjacent",
                     cyc, m_chipselect, m_read, m_write, prev_strobe);
          end
        end else if (m_chipselect) begin
          n_vec++;
          n_fail++;
          $display("FAIL cs_without_strobe cyc=%0d: cs=1, required 0", cyc);
        end
        prev_strobe = strobe;
        if (m_read && m_address == 3'd0) begin
          n_stat++;
          stat_times.push_back(cyc);
        end
        if (m_read && m_address == 3'd1) n_msgrd++;
        if (m_write) begin
          n_wr++;
          last_wr_addr = m_address;
          last_wr_data = m_writedata;
          last_wr_cyc  = cyc;
        end
        if (prev_stall) begin
          n_vec++;
          if (!tx_valid || tx_data !== held) begin
            n_fail++;
            $display("FAIL tx_hold cyc=%0d: valid=%b data=%h, required valid=1 data=%h",
                     cyc, tx_valid, tx_data, held);
          end
        end
        if (tx_valid && tx_ready) begin
          n_vec++;
          n_acc++;
          last_acc_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected cyc=%0d: byte %h, required no byte", cyc, tx_data);
          end else begin
            exp_b = exp_q.pop_front();
            if (tx_data !== exp_b) begin
              n_fail++;
              $display("FAIL tx_byte cyc=%0d: got %h required %h", cyc, tx_data, exp_b);
            end
          end
        end
        prev_stall = tx_valid && !tx_ready;
        held       = tx_data;
      end else begin
        prev_strobe = 1'b0;
        prev_stall  = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input logic [79:0] pkt, input int nbytes);
    for (int i = 0; i < nbytes; i++) exp_q.push_back(pkt[79-8*i -: 8]);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, "_bus"}, {m_chipselect, m_read, m_write, m_address, m_writedata}, 64'h0);
    chk({name, "_tx"}, {tx_valid, tx_data}, 64'h0);
    chk({name, "_cnt"}, {msg_count, sync_err_count, busy}, 64'h0);
  endtask

  task automatic wait_msgs(input int target, input int budget, input string name);
    int n = 0;
    while (msg_count != 16'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, msg_count, 64'(target));
  endtask

  initial begin
    int t_rd, t_tx, n, base, wr_base, msg_base, seen;
    reset_n   = 1'b0;
    enable    = 1'b0;
    flush_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");

    // Case 1: one message, tx_ready always high; also first-byte latency.
    fifo = {ID, W1A, W2A};
    push_pkt(PKT_A, 10);
    enable  = 1'b1;
    reset_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_read && n < 10);
    chk("first_poll_addr", {m_read, m_address}, {1'b1, 3'd0});
    t_rd = cyc;
    n = 0;
    while (!tx_valid && n < 30) begin @(negedge clk); n++; end
    t_tx = cyc;
    chk("first_byte_latency", 64'(t_tx - t_rd), 64'd8);
    wait_msgs(1, 10 * P, "case1_msg_count");
    chk("case1_drained", 64'(exp_q.size()), 64'd0);
    chk("case1_msg_reads", 64'(n_msgrd), 64'd3);
    chk("case1_total_reads", 64'(n_stat + n_msgrd), 64'd4);

    // Case 2: only two words held -> STATUS polls only, P idle cycles plus read and capture.
    fifo = {ID, W1A};
    @(negedge clk);
    stat_times.delete();
    base = n_msgrd;
    repeat (4 * (P + 2) + 2) @(negedge clk);
    chk("case2_poll_count_ok", 64'(stat_times.size() >= 3), 64'd1);
    if (stat_times.size() >= 3) begin
      chk("case2_spacing_a", 64'(stat_times[1] - stat_times[0]), 64'(P + 2));
      chk("case2_spacing_b", 64'(stat_times[2] - stat_times[1]), 64'(P + 2));
    end
    chk("case2_no_msg_reads", 64'(n_msgrd - base), 64'd0);

    // Case 3: leading junk word -> one sync error, then a correct packet.
    fifo = {32'h0000_DEAD, ID, W1B, W2B};
    push_pkt(PKT_B, 10);
    wait_msgs(2, 10 * P, "case3_msg_count");
    chk("case3_sync_err", sync_err_count, 64'd1);
    chk("case3_drained", 64'(exp_q.size()), 64'd0);

    // Case 4: tx_ready high one cycle in three; monitor checks hold during stalls.
    rdy_mode = 1;
    fifo = {ID, W1A, W2A};
    push_pkt(PKT_A, 10);
    wait_msgs(3, 12 * P, "case4_msg_count");
    chk("case4_drained", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;

    // Case 5: flush request while the second message word is being captured.
    wr_base = n_wr;
    fifo = {ID, W1C, W2C};
    push_pkt(PKT_C, 10);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 5 * P) begin
      @(negedge clk);
      n++;
      if (m_read && m_address == 3'd1) seen++;
    end
    chk("case5_reached_w1", 64'(seen), 64'd2);
    @(posedge clk);
    #1 flush_req = 1'b1;
    @(posedge clk);
    #1 flush_req = 1'b0;
    wait_msgs(4, 10 * P, "case5_msg_count");
    chk("case5_drained", 64'(exp_q.size()), 64'd0);
    n = 0;
    while (n_wr == wr_base && n < 10) begin @(negedge clk); n++; end
    chk("case5_write_addr", last_wr_addr, 64'd0);
    chk("case5_write_data", last_wr_data, 64'h10);
    chk("case5_write_after_pkt", 64'(last_wr_cyc > last_acc_cyc), 64'd1);
    repeat (2 * P) @(negedge clk);
    chk("case5_single_write", 64'(n_wr - wr_base), 64'd1);

    // Case 6: reset while the fifth byte (index 4) is presented.
    fifo = {ID, W1A, W2A};
    push_pkt(PKT_A, 4);
    base = n_acc;
    n = 0;
    while (n_acc != base + 4 && n < 10 * P) begin @(posedge clk); n++; end
    rdy_mode = 2;
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("case6_presenting_byte4", {tx_valid, tx_data}, {1'b1, 8'hF0});
    @(negedge clk);
    check_zero_outputs("case6_reset");
    chk("case6_drained", 64'(exp_q.size()), 64'd0);
    reset_n  = 1'b1;
    rdy_mode = 0;
    msg_base = n_msgrd;
    n = 0;
    do begin @(negedge clk); n++; end while (!(m_read || m_write) && n < 10);
    chk("case6_first_strobe_status", {m_read, m_write, m_address}, {1'b1, 1'b0, 3'd0});
    chk("case6_no_msg_read", 64'(n_msgrd - msg_base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
